regfile_wb_ctrl: RTL and testbench

//   Write-back controller directly upstream of the 32x32 register file write port.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 52 +++++
 rtl/regfile_wb_ctrl.sv | 137 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants, write-back FSM state encoding and request/forwarding types.
package regfile_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic                 hit;
        logic [RF_DATA_W-1:0] data;
    } fwd_res_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH x 37-bit synchronous write-request FIFO; exposes storage and read pointer for forwarding.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          push,
    input  logic          pop,
    input  wb_req_t       din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output wb_req_t       entries [DEPTH],
    output logic [PW-1:0] rd_ptr
);

    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage carries no reset; only pointers and count define which entries are live.
    always_ff @(posedge Clk) begin
        if (do_push) entries[wr_ptr] <= din;
    end

    // NOTE: state updates use <= so every register samples pre-edge values regardless of order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller feeding the 32x32 register file write port: FIFO buffering plus zeroing sweep.
// Optional combinational forwarding of pending writes is enabled with `define REGFILE_WB_FWD_EN.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [RF_DATA_W-1:0] wb_data,
    input  logic                 clear_req,
    output logic                 busy,
    output logic [RF_ADDR_W-1:0] WriteRegister,
    output logic [RF_DATA_W-1:0] WriteData,
    output logic                 RegWrite
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [RF_ADDR_W-1:0] fwd_addr1,
    input  logic [RF_ADDR_W-1:0] fwd_addr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [RF_DATA_W-1:0] fwd_data1,
    output logic [RF_DATA_W-1:0] fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_state_e            state;
    logic [RF_ADDR_W-1:0] clr_cnt;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [PW-1:0]        rd_ptr;
    wb_req_t              entries [DEPTH];
    wb_req_t              head;

    assign wb_ready = (state == ST_RUN) && (count < CW'(DEPTH));
    assign busy     = (state != ST_RUN);
    // Register 0 is hard-wired downstream: complete the handshake but never queue it.
    assign push     = wb_valid && wb_ready && (wb_addr != '0);
    assign pop      = (state != ST_CLEAR) && !empty;
    assign head     = entries[rd_ptr];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push    (push),
        .pop     (pop),
        .din     ('{addr: wb_addr, data: wb_data}),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .entries (entries),
        .rd_ptr  (rd_ptr)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= ST_CLEAR;
            clr_cnt       <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    RegWrite      <= 1'b1;
                    WriteRegister <= clr_cnt;
                    WriteData     <= '0;
                    clr_cnt       <= clr_cnt + RF_ADDR_W'(1);
                    if (clr_cnt == RF_ADDR_W'(RF_NUM_REGS - 1)) state <= ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    RegWrite <= pop;
                    if (pop) begin
                        WriteRegister <= head.addr;
                        WriteData     <= head.data;
                    end
                    if (state == ST_RUN && clear_req) begin
                        state <= ST_DRAIN;
                    end else if (state == ST_DRAIN && empty) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // wb_ready already excludes the full case; a push into a full FIFO would silently drop data.
    push_never_full: assert property (@(posedge Clk) disable iff (Reset) !(push && full));

`ifdef REGFILE_WB_FWD_EN
    // Later matches override earlier ones, so the youngest pending write wins.
    function automatic fwd_res_t fwd_lookup(input logic [RF_ADDR_W-1:0] addr);
        fwd_res_t res;
        // NOTE: every result field is given a value up front so no path leaves it latched.
        res = '0;
        if (addr != '0) begin
            if (state == ST_CLEAR && addr < clr_cnt) res.hit = 1'b1;
            if (RegWrite && WriteRegister == addr) begin
                res.hit  = 1'b1;
                res.data = WriteData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count && entries[rd_ptr + PW'(i)].addr == addr) begin
                    res.hit  = 1'b1;
                    res.data = entries[rd_ptr + PW'(i)].data;
                end
            end
        end
        return res;
    endfunction

    fwd_res_t fwd1;
    fwd_res_t fwd2;

    always_comb begin
        fwd1 = fwd_lookup(fwd_addr1);
        fwd2 = fwd_lookup(fwd_addr2);
    end

    assign fwd_hit1  = fwd1.hit;
    assign fwd_data1 = fwd1.data;
    assign fwd_hit2  = fwd2.hit;
    assign fwd_data2 = fwd2.data;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench: regfile_wb_ctrl paired with a behavioural 32x32 register file, checked via two read ports.
module tb_regfile_wb_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        clear_req;
    logic        busy;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  fwd_addr1;
    logic [4:0]  fwd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    logic [31:0] rf [32];
    logic        rf_fill;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    regfile_wb_ctrl #(.DEPTH(4)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .clear_req     (clear_req),
        .busy          (busy),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite)
`ifdef REGFILE_WB_FWD_EN
        ,
        .fwd_addr1     (fwd_addr1),
        .fwd_addr2     (fwd_addr2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2)
`endif
    );

    // Register file: filled with a marker pattern during reset so the sweep is observable.
    always @(posedge Clk) begin
        if (rf_fill) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h5A5A_5A5A;
        end else if (RegWrite) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    assign ReadData1 = rf[ReadRegister1];
    assign ReadData2 = rf[ReadRegister2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one active edge and park on the following negedge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic check_sweep(input string tag);
        for (int k = 0; k < 32; k++) begin
            step();
            check($sformatf("%s_wr%0d", tag, k), {RegWrite, WriteRegister}, {1'b1, 5'(k)});
            check($sformatf("%s_wd%0d", tag, k), WriteData, 32'h0);
            check($sformatf("%s_busy%0d", tag, k), busy, (k != 31));
            check($sformatf("%s_rdy%0d", tag, k), wb_ready, (k == 31));
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            ReadRegister1 = 5'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), ReadData1, 32'h0);
        end
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; rf_fill = 1'b1; clear_req = 1'b0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        drive(1'b0, 5'd0, 32'h0);
`ifdef REGFILE_WB_FWD_EN
        fwd_addr1 = '0; fwd_addr2 = '0;
`endif

        // 1. Reset values, then the 32-cycle zeroing sweep.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_wreg", WriteRegister, 5'd0);
        check("rst_wdata", WriteData, 32'h0);
        check("rst_ready", wb_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        Reset = 1'b0; rf_fill = 1'b0;
        check_sweep("sweep");
        step();
        check("post_sweep_idle", RegWrite, 1'b0);
        check_all_zero("sweep_zero");

        // 2. Single write latency: accept at N, output at N+1, committed at N+2.
        drive(1'b1, 5'd3, 32'hDEAD_BEEF);
        check("lat_ready", wb_ready, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'h0);
        check("lat_n_idle", RegWrite, 1'b0);
        step();
        check("lat_n1", {RegWrite, WriteRegister}, {1'b1, 5'd3});
        check("lat_n1_data", WriteData, 32'hDEAD_BEEF);
        ReadRegister1 = 5'd3;
        #1;
        check("lat_n1_rf", ReadData1, 32'h0);
        step();
        check("lat_n2_rf", ReadData1, 32'hDEAD_BEEF);
        check("lat_n2_idle", RegWrite, 1'b0);

        // 3. Five back-to-back requests issue one per cycle in push order.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(i + 1), 32'h100 + 32'(i));
            check($sformatf("b2b_ready%0d", i), wb_ready, 1'b1);
            step();
            if (i > 0) begin
                check($sformatf("b2b_wr%0d", i), {RegWrite, WriteRegister}, {1'b1, 5'(i)});
                check($sformatf("b2b_wd%0d", i), WriteData, 32'h100 + 32'(i - 1));
            end
        end
        drive(1'b0, 5'd0, 32'h0);
        step();
        check("b2b_last_wr", {RegWrite, WriteRegister}, {1'b1, 5'd5});
        check("b2b_last_wd", WriteData, 32'h104);
        step();
        check("b2b_idle", RegWrite, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            ReadRegister2 = 5'(i);
            #1;
            check($sformatf("b2b_rf%0d", i), ReadData2, 32'h100 + 32'(i - 1));
        end
        @(negedge Clk);

        // 4. Writes to register 0 handshake but are dropped.
        drive(1'b1, 5'd0, 32'h15);
        check("r0_ready", wb_ready, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'h0);
        check("r0_no_write_a", RegWrite, 1'b0);
        step();
        check("r0_no_write_b", RegWrite, 1'b0);
        ReadRegister2 = 5'd0;
        #1;
        check("r0_rf", ReadData2, 32'h0);
        @(negedge Clk);

        // 5. clear_req drains queued writes, then sweeps; clear_req during CLEAR is ignored.
        drive(1'b1, 5'd10, 32'h111);
        step();
        drive(1'b1, 5'd11, 32'h222);
        step();
        check("clr_first_out", {RegWrite, WriteRegister}, {1'b1, 5'd10});
        drive(1'b1, 5'd12, 32'h333);
        clear_req = 1'b1;
        check("clr_same_edge_ready", wb_ready, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'h0);
        clear_req = 1'b0;
        check("drain_busy", busy, 1'b1);
        check("drain_ready", wb_ready, 1'b0);
        check("drain_wr11", {RegWrite, WriteRegister}, {1'b1, 5'd11});
        step();
        check("drain_wr12", {RegWrite, WriteRegister}, {1'b1, 5'd12});
        check("drain_wd12", WriteData, 32'h333);
        check("drain_ready2", wb_ready, 1'b0);
        step();
        check("drain_gap", RegWrite, 1'b0);
        check("drain_gap_busy", busy, 1'b1);
        for (int k = 0; k < 32; k++) begin
            clear_req = (k == 5);
            step();
            check($sformatf("clr_wr%0d", k), {RegWrite, WriteRegister}, {1'b1, 5'(k)});
            check($sformatf("clr_rdy%0d", k), wb_ready, (k == 31));
        end
        clear_req = 1'b0;
        step();
        check("clr_done_idle", RegWrite, 1'b0);
        check_all_zero("clr_zero");

        // 6. Reset during the sweep at cnt=17 restarts it from register 0.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("mid_drain_busy", busy, 1'b1);
        step();
        repeat (17) step();
        check("mid_at16", {RegWrite, WriteRegister}, {1'b1, 5'd16});
        Reset = 1'b1;
        #1;
        check("mid_rst_regwrite", RegWrite, 1'b0);
        check("mid_rst_wreg", WriteRegister, 5'd0);
        check("mid_rst_busy", busy, 1'b1);
        check("mid_rst_ready", wb_ready, 1'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check_sweep("resweep");

`ifdef REGFILE_WB_FWD_EN
        // 7. Forwarding: FIFO tail beats the output stage; address 0 never hits.
        drive(1'b1, 5'd7, 32'hAA);
        step();
        drive(1'b1, 5'd7, 32'hBB);
        step();
        drive(1'b0, 5'd0, 32'h0);
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd0;
        #1;
        check("fwd_hit1", fwd_hit1, 1'b1);
        check("fwd_data1", fwd_data1, 32'hBB);
        check("fwd_hit2_r0", fwd_hit2, 1'b0);
        fwd_addr2 = 5'd5;
        #1;
        check("fwd_hit2_miss", fwd_hit2, 1'b0);
        step();
        check("fwd_out_hit", fwd_hit1, 1'b1);
        check("fwd_out_data", fwd_data1, 32'hBB);
        step();
        check("fwd_retired", fwd_hit1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
